// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: kind codes, opcode/funct fields,
// the NOP word and the encoder FSM states.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      K_ADDU = 3'd0,
      K_SUBU = 3'd1,
      K_ORI  = 3'd2,
      K_LW   = 3'd3,
      K_SW   = 3'd4,
      K_BEQ  = 3'd5,
      K_LUI  = 3'd6,
      K_J    = 3'd7
   } kind_t;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_PAD = 1'b1
   } enc_state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Control transfers that own a delay slot.
   function automatic logic is_branch(input kind_t k);
      return (k == K_BEQ) || (k == K_J);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              overflow;

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
      output in_ready, wr_en, wr_addr, wr_data, count, full, overflow
   );

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
      input  in_ready, wr_en, wr_addr, wr_data, count, full, overflow
   );
endinterface

// File: rtl/instr_encoder_pack.sv
// Purely combinational packer: decoded fields -> 32-bit MIPS word.
// Fields a format does not use are forced to zero.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  kind_t       kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] target_i,
   output logic [31:0] word_o
);

   // Format selection per instruction kind.
   always_comb begin
      word_o = NOP_WORD;
      case (kind_i)
         K_ADDU:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_ADDU};
         K_SUBU:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_SUBU};
         K_ORI:   word_o = {OP_ORI, rs_i, rt_i, imm_i};
         K_LW:    word_o = {OP_LW, rs_i, rt_i, imm_i};
         K_SW:    word_o = {OP_SW, rs_i, rt_i, imm_i};
         K_BEQ:   word_o = {OP_BEQ, rs_i, rt_i, imm_i};
         K_LUI:   word_o = {OP_LUI, 5'd0, rt_i, imm_i};
         K_J:     word_o = {OP_J, target_i};
         default: word_o = NOP_WORD;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instructions into instruction memory with an auto-incrementing address.
// Optional macro ENC_DELAY_SLOT_PAD_EN inserts a NOP after every BEQ/J.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int BASE   = 0,
   parameter int DEPTH  = 1024
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   instr_encoder_if.slave bus
);

   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

   enc_state_t        state_q, state_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              ovf_q, ovf_d;
   logic              in_ready_s;
   logic              accept_s;
   logic [31:0]       word_s;
   kind_t             kind_s;

   assign kind_s     = kind_t'(bus.in_kind);
   assign in_ready_s = rst_n & ~clear & ~full_q & (state_q == ST_RUN);
   assign accept_s   = bus.in_valid & in_ready_s;

   instr_pack u_pack (
      .kind_i   (kind_s),
      .rs_i     (bus.in_rs),
      .rt_i     (bus.in_rt),
      .rd_i     (bus.in_rd),
      .imm_i    (bus.in_imm),
      .target_i (bus.in_target),
      .word_o   (word_s)
   );

   // Next-state: clear, then a pending delay-slot NOP, then a fresh accept.
   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      ptr_d     = ptr_q;
      wr_data_d = wr_data_q;
      count_d   = count_q;
      full_d    = full_q;
      ovf_d     = ovf_q;
      if (clear) begin
         state_d   = ST_RUN;
         wr_addr_d = BASE_C;
         ptr_d     = BASE_C;
         count_d   = '0;
         full_d    = 1'b0;
         ovf_d     = 1'b0;
      end else if (state_q == ST_PAD) begin
         state_d = ST_RUN;
         if (count_q < DEPTH_C) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = NOP_WORD;
            ptr_d     = ptr_q + ADDR_W'(1);
            count_d   = count_q + (ADDR_W+1)'(1);
            full_d    = ((count_q + (ADDR_W+1)'(1)) == DEPTH_C);
         end else begin
            ovf_d  = 1'b1;
            full_d = 1'b1;
         end
      end else if (accept_s) begin
         wr_en_d   = 1'b1;
         wr_addr_d = ptr_q;
         wr_data_d = word_s;
         ptr_d     = ptr_q + ADDR_W'(1);
         count_d   = count_q + (ADDR_W+1)'(1);
         full_d    = ((count_q + (ADDR_W+1)'(1)) == DEPTH_C);
`ifdef ENC_DELAY_SLOT_PAD_EN
         if (is_branch(kind_s)) begin
            state_d = ST_PAD;
         end else begin
            state_d = ST_RUN;
         end
`else
         state_d = ST_RUN;
`endif
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         wr_en_q   <= 1'b0;
         wr_addr_q <= BASE_C;
         ptr_q     <= BASE_C;
         wr_data_q <= 32'h0000_0000;
         count_q   <= '0;
         full_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         ptr_q     <= ptr_d;
         wr_data_q <= wr_data_d;
         count_q   <= count_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.in_ready = in_ready_s;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.count    = count_q;
   assign bus.full     = full_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder (DEPTH=4) against a behavioural memory-image model.
module tb_instr_encoder;

   localparam int ADDR_W = 10;
   localparam int BASE   = 0;
   localparam int DEPTH  = 4;
`ifdef ENC_DELAY_SLOT_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic clear;
   int   vectors = 0;
   int   miscompares = 0;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: words written so far, next address, sticky flags, pending delay slot.
   bit          m_wr_en;
   logic [31:0] m_wr_data;
   int          m_wr_addr, m_n, m_next;
   bit          m_full, m_ovf, m_pad;
   bit          exp_ready, obs_ready;

   logic [55:0] obs_vec, exp_vec;
   assign obs_vec = {bus.wr_en, bus.wr_addr, bus.wr_data, bus.count, bus.full, bus.overflow};
   assign exp_vec = {m_wr_en, ADDR_W'(m_wr_addr), m_wr_data, (ADDR_W+1)'(m_n), m_full, m_ovf};

   function automatic logic [31:0] ref_encode(input logic [2:0] k, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [31:0] rd,
                                              input logic [31:0] imm, input logic [31:0] tgt);
      logic [31:0] w;
      case (k)
         3'd0:    w = (rs << 21) | (rt << 16) | (rd << 11) | 32'h21;
         3'd1:    w = (rs << 21) | (rt << 16) | (rd << 11) | 32'h23;
         3'd2:    w = (32'd13 << 26) | (rs << 21) | (rt << 16) | imm;
         3'd3:    w = (32'd35 << 26) | (rs << 21) | (rt << 16) | imm;
         3'd4:    w = (32'd43 << 26) | (rs << 21) | (rt << 16) | imm;
         3'd5:    w = (32'd4 << 26) | (rs << 21) | (rt << 16) | imm;
         3'd6:    w = (32'd15 << 26) | (rt << 16) | imm;
         default: w = (32'd2 << 26) | tgt;
      endcase
      return w;
   endfunction

   task automatic model_write(input logic [31:0] w);
      m_wr_en   = 1'b1;
      m_wr_addr = m_next;
      m_wr_data = w;
      m_next    = m_next + 1;
      m_n       = m_n + 1;
      m_full    = (m_n == DEPTH);
   endtask

   // Drive one cycle of inputs, predict, and advance to just after the edge.
   task automatic apply(input bit rn, input bit clr, input bit v, input logic [2:0] k,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt);
      rst_n = rn; clear = clr; bus.in_valid = v; bus.in_kind = k;
      bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd; bus.in_imm = imm; bus.in_target = tgt;
      #1;
      obs_ready = bus.in_ready;
      exp_ready = rn && !clr && !m_full && !m_pad;
      m_wr_en = 1'b0;
      if (!rn || clr) begin
         if (!rn) m_wr_data = 32'h0;
         m_wr_addr = BASE; m_next = BASE; m_n = 0;
         m_full = 1'b0; m_ovf = 1'b0; m_pad = 1'b0;
      end else if (m_pad) begin
         m_pad = 1'b0;
         if (m_n < DEPTH) model_write(32'h0);
         else begin m_ovf = 1'b1; m_full = 1'b1; end
      end else if (v && exp_ready) begin
         model_write(ref_encode(k, 32'(rs), 32'(rt), 32'(rd), 32'(imm), 32'(tgt)));
         if (PAD_EN && (k == 3'd5 || k == 3'd7)) m_pad = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      apply(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
   endtask

   task automatic test_reset();
      apply(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      apply(1'b0, 1'b0, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      vectors++;
      if (obs_vec !== {1'b0, 10'd0, 32'h0, 11'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state got=%h want=%h", obs_vec, {1'b0, 10'd0, 32'h0, 11'd0, 1'b0, 1'b0});
      end
      vectors++;
      if (obs_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready got=%b want=0", obs_ready);
      end
   endtask

   task automatic test_addu();
      apply(1'b1, 1'b0, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      vectors++;
      if (obs_vec !== exp_vec || bus.wr_data !== 32'h00221821 || bus.wr_addr !== 10'd0 || bus.count !== 11'd1) begin
         miscompares++;
         $display("FAIL addu got=%h want=%h (data want 00221821)", obs_vec, exp_vec);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ks [3] = '{3'd2, 3'd3, 3'd6};
      logic [4:0]  rss[3] = '{5'd0, 5'd0, 5'd7};
      logic [4:0]  rts[3] = '{5'd1, 5'd2, 5'd3};
      logic [15:0] ims[3] = '{16'h1234, 16'h0004, 16'hABCD};
      logic [31:0] ws [3] = '{32'h34011234, 32'h8C020004, 32'h3C03ABCD};
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, 1'b1, ks[i], rss[i], rts[i], 5'd9, ims[i], 26'h0);
         vectors++;
         if (obs_vec !== exp_vec || bus.wr_en !== 1'b1 || bus.wr_data !== ws[i] || bus.wr_addr !== 10'(i + 1)) begin
            miscompares++;
            $display("FAIL b2b_%0d got=%h want=%h (data want %h)", i, obs_vec, exp_vec, ws[i]);
         end
      end
   endtask

   task automatic test_full_and_clear();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 1'b0, 1'b1, 3'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
         vectors++;
         if (obs_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.full !== 1'b1 || bus.wr_addr !== 10'd3 || obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL full_hold_%0d got=%h rdy=%b want=%h rdy=0", i, obs_vec, obs_ready, exp_vec);
         end
      end
      apply(1'b1, 1'b1, 1'b1, 3'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
      vectors++;
      if (obs_ready !== 1'b0 || obs_vec !== exp_vec || bus.wr_data !== 32'h3C03ABCD) begin
         miscompares++;
         $display("FAIL clear_edge got=%h rdy=%b want=%h", obs_vec, obs_ready, exp_vec);
      end
      apply(1'b1, 1'b0, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      vectors++;
      if (obs_vec !== exp_vec || bus.wr_addr !== 10'd0 || bus.count !== 11'd1 || bus.wr_en !== 1'b1) begin
         miscompares++;
         $display("FAIL after_clear got=%h want=%h", obs_vec, exp_vec);
      end
   endtask

   task automatic test_branch();
      apply(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      apply(1'b1, 1'b0, 1'b1, 3'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
      vectors++;
      if (obs_vec !== exp_vec || bus.wr_data !== 32'h1022FFFF || bus.wr_addr !== 10'd0) begin
         miscompares++;
         $display("FAIL beq got=%h want=%h", obs_vec, exp_vec);
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, 1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 16'h0, 26'hC00);
         vectors++;
         if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL branch_seq_%0d got=%h rdy=%b want=%h rdy=%b", i, obs_vec, obs_ready, exp_vec, exp_ready);
         end
         if (i == 0) begin
            vectors++;
            if (bus.wr_data !== (PAD_EN ? 32'h0 : 32'h08000C00) || obs_ready !== !PAD_EN) begin
               miscompares++;
               $display("FAIL after_beq data=%h rdy=%b want data=%h rdy=%b", bus.wr_data, obs_ready,
                        PAD_EN ? 32'h0 : 32'h08000C00, !PAD_EN);
            end
         end
      end
   endtask

   task automatic test_last_slot();
      apply(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b1, 3'd2, 5'd3, 5'd4, 5'd0, 16'(i), 26'h0);
      apply(1'b1, 1'b0, 1'b1, 3'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
      vectors++;
      if (obs_vec !== exp_vec || bus.wr_addr !== 10'd3 || bus.full !== 1'b1) begin
         miscompares++;
         $display("FAIL last_slot_beq got=%h want=%h", obs_vec, exp_vec);
      end
      idle();
      vectors++;
      if (obs_vec !== exp_vec || bus.wr_en !== 1'b0 || bus.overflow !== PAD_EN || bus.full !== 1'b1) begin
         miscompares++;
         $display("FAIL last_slot_pad got=%h want=%h ovf want %b", obs_vec, exp_vec, PAD_EN);
      end
   endtask

   task automatic test_reset_mid_stream();
      apply(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      apply(1'b1, 1'b0, 1'b1, 3'd5, 5'd3, 5'd3, 5'd0, 16'h0010, 26'h0);
      apply(1'b0, 1'b0, 1'b1, 3'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
      vectors++;
      if (obs_vec !== {1'b0, 10'd0, 32'h0, 11'd0, 1'b0, 1'b0} || obs_vec !== exp_vec) begin
         miscompares++;
         $display("FAIL reset_mid got=%h want=%h", obs_vec, exp_vec);
      end
      idle();
      vectors++;
      if (obs_vec !== exp_vec || bus.wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_nopad got=%h want=%h", obs_vec, exp_vec);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 14) == 0), ($urandom_range(0, 3) != 0),
               3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
         vectors++;
         if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL random_%0d got=%h rdy=%b want=%h rdy=%b", i, obs_vec, obs_ready, exp_vec, exp_ready);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; bus.in_valid = 1'b0; bus.in_kind = 3'd0;
      bus.in_rs = 5'd0; bus.in_rt = 5'd0; bus.in_rd = 5'd0; bus.in_imm = 16'h0; bus.in_target = 26'h0;
      m_wr_en = 1'b0; m_wr_data = 32'h0; m_wr_addr = BASE; m_n = 0; m_next = BASE;
      m_full = 1'b0; m_ovf = 1'b0; m_pad = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_addu();
      test_back_to_back();
      test_full_and_clear();
      test_branch();
      test_last_slot();
      test_reset_mid_stream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction-decode control unit: accepts decoded instruction fields (kind, rs, rt, rd, imm, target) over a valid/ready handshake.
- Packs each instruction into a 32-bit MIPS word for the supported set (addu, subu, ori, lw, sw, beq, lui, j).
- Streams packed words into instruction memory through a registered write port with an auto-incrementing word address.
- Used by the testbench/boot loader to build programs for the pipelined core.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- BASE, 0, first word address written after reset/clear.
- DEPTH, 1024, words available from BASE; writes beyond this are refused.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous restart: address back to BASE, count/full/overflow cleared.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept this cycle.
- in_kind  in  3  0 ADDU, 1 SUBU, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 LUI, 7 J.
- in_rs  in  5  source register.
- in_rt  in  5  target register.
- in_rd  in  5  destination register (R-type only).
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target field.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/clear.
- full  out  1  DEPTH words written.
- overflow  out  1  sticky: a word was dropped for lack of space.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - wr_en=0, wr_data=0, wr_addr=BASE, count=0, full=0, overflow=0, FSM=RUN.
  - Reset mid-stream aborts any pending word; nothing is written that cycle.
- Handshake:
  - Accept when in_valid & in_ready at the clock edge.
  - in_ready = rst_n & ~clear & ~full & (FSM==RUN).
  - in_ready is independent of in_valid and the field inputs.
- Latency:
  - Bundle accepted at edge N gives wr_en=1 for exactly the cycle after N, with wr_addr and wr_data registered.
  - Back-to-back accepts give a write every cycle.
  - Address increments by 1 after each write; count increments with it.
- Encoding (op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, funct[5:0]):
  - ADDU: op 0x00, funct 0x21.
  - SUBU: op 0x00, funct 0x23.
  - ORI: op 0x0D, rs, rt, imm.
  - LW: op 0x23, rs, rt, imm.
  - SW: op 0x2B, rs, rt, imm.
  - BEQ: op 0x04, rs, rt, imm.
  - LUI: op 0x0F, rs forced to 0, rt, imm.
  - J: op 0x02, target.
  - Unused fields are ignored (forced 0 in the word).
- Full:
  - full=1 the cycle after count reaches DEPTH.
  - in_ready=0 while full.
  - wr_addr holds BASE+DEPTH-1 after the last write (no wrap).
- clear:
  - Same edge effect as reset except wr_data is held.
  - If clear and an accept coincide, clear wins: the bundle is not accepted because in_ready=0.
- FSM: RUN and PAD (PAD is used only with the optional feature). Without the feature, FSM stays in RUN.

Optional Feature:
- Macro ENC_DELAY_SLOT_PAD_EN.
- When defined:
  - Accepting a BEQ or J moves the FSM RUN->PAD; in_ready=0 in PAD.
  - The cycle after the branch write, a NOP (0x00000000) is written at the next address; the FSM then returns to RUN.
  - If the branch occupies the last slot, the NOP is dropped, overflow=1, full=1, FSM returns to RUN.
  - clear or reset in PAD returns to RUN with no NOP.
- When undefined: no padding; overflow remains 0 forever.

Decomposition:
- Shared package (e.g. mips_pkg):
  - kind enum.
  - opcode constants OP_RTYPE/ORI/LW/SW/BEQ/LUI/J.
  - funct constants FN_ADDU/FN_SUBU.
  - NOP word constant.
  - Reuse these in the decoder.
- One natural sub-module: instr_pack, purely combinational fields->32-bit word. The top holds the handshake, address counter and FSM.

Test Plan:
- After reset, ADDU rs=1 rt=2 rd=3 -> next cycle wr_en=1, wr_addr=0, wr_data=0x00221821, count=1.
- Back-to-back ORI rt=1 imm=0x1234, LW rt=2 imm=4, LUI rs=7 rt=3 imm=0xABCD -> 0x34011234 @1, 0x8C020004 @2, 0x3C03ABCD @3 on consecutive cycles.
- DEPTH=4: valid held high for 6 bundles -> exactly 4 writes, full=1, in_ready=0, wr_addr=3; then clear -> next write at address 0, count=1.
- BEQ rs=1 rt=2 imm=0xFFFF, then J target=0xC00 -> 0x1022FFFF, 0x08000C00 (no pad build).
- Pad build: BEQ as above -> 0x1022FFFF @0, 0x00000000 @1, in_ready low one cycle; with DEPTH=1, BEQ -> one write, overflow=1, full=1.
- Assert rst_n=0 the cycle after an accept -> no wr_en, all outputs at reset values.
